// File: rtl/program_sequencer.sv
// program_sequencer: PC sequencer with return stack, single-level interrupts and PSR save/restore
module program_sequencer #(
    parameter int                ADDR_W      = 16,
    parameter int                STACK_DEPTH = 8,
    parameter int                IRQ_N       = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(16'h0010),
    parameter int                VEC_STRIDE  = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             step,
    input  logic [2:0]                       op,
    input  logic [ADDR_W-1:0]                target,
    input  logic                             cond,
    input  logic [4:0]                       psr_in,
    input  logic [IRQ_N-1:0]                 irq,
    input  logic [IRQ_N-1:0]                 irq_mask,
    output logic [ADDR_W-1:0]                pc,
    output logic [4:0]                       psr_out,
    output logic                             psr_restore,
    output logic [IRQ_N-1:0]                 irq_ack,
    output logic                             in_isr,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_ovf,
    output logic                             stack_unf
);
    localparam int DW = $clog2(STACK_DEPTH+1);
    localparam int IW = IRQ_N > 1 ? $clog2(IRQ_N) : 1;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];
    logic [ADDR_W-1:0] inc, npc, top, vec, push_val;
    logic [IRQ_N-1:0]  pend;
    logic [IW-1:0]     idx;
    logic [4:0]        saved_psr;
    logic              full, empty, is_call, is_ret, is_reti, take, restore, push_en;

    always_comb begin
        inc     = pc + ADDR_W'(1);
        full    = depth == DW'(STACK_DEPTH);
        empty   = depth == '0;
        is_call = op == 3'b011;
        is_ret  = op == 3'b100 || op == 3'b101;
        is_reti = op == 3'b101;
        top     = stack[0];
        for (int i = 0; i < STACK_DEPTH; i++)
            if (depth == DW'(i + 1)) top = stack[i];
        npc = op == 3'b001 ? target :
              op == 3'b010 ? (cond ? pc + target : inc) :
              op == 3'b110 ? pc :
              is_call      ? target :
              (is_ret && !empty) ? top : inc;
        pend = irq & irq_mask;
        idx  = '0;
        for (int i = IRQ_N - 1; i >= 0; i--)
            if (pend[i]) idx = IW'(i);
        vec      = VEC_BASE + ADDR_W'(idx) * ADDR_W'(VEC_STRIDE);
        take     = step && |pend && !in_isr && !is_call && !is_ret && !full;
        restore  = is_reti && in_isr && !empty;
        push_en  = step && (take || (is_call && !full));
        push_val = take ? npc : inc;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < STACK_DEPTH; i++)
            if (push_en && depth == DW'(i)) stack[i] <= push_val;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_ADDR;
            depth       <= '0;
            in_isr      <= 1'b0;
            stack_ovf   <= 1'b0;
            stack_unf   <= 1'b0;
            irq_ack     <= '0;
            psr_restore <= 1'b0;
            psr_out     <= '0;
            saved_psr   <= '0;
        end else begin
            irq_ack     <= '0;
            psr_restore <= 1'b0;
            if (step) begin
                pc <= take ? vec : npc;
                if (take) begin
                    depth     <= depth + DW'(1);
                    in_isr    <= 1'b1;
                    saved_psr <= psr_in;
                    irq_ack   <= IRQ_N'(1) << idx;
                end else if (is_call) begin
                    if (full) stack_ovf <= 1'b1;
                    else depth <= depth + DW'(1);
                end else if (is_ret) begin
                    if (empty) stack_unf <= 1'b1;
                    else depth <= depth - DW'(1);
                    if (restore) begin
                        in_isr      <= 1'b0;
                        psr_restore <= 1'b1;
                        psr_out     <= saved_psr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and random stimulus against a queue-based reference model
module tb_program_sequencer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        step = 1'b0;
    logic [2:0]  op = '0;
    logic [15:0] target = '0;
    logic        cond = 1'b0;
    logic [4:0]  psr_in = '0;
    logic [3:0]  irq = '0;
    logic [3:0]  irq_mask = '0;
    logic [15:0] pc;
    logic [4:0]  psr_out;
    logic        psr_restore;
    logic [3:0]  irq_ack;
    logic        in_isr;
    logic [3:0]  depth;
    logic        stack_ovf, stack_unf;

    program_sequencer dut (
        .clock(clock), .reset(reset), .step(step), .op(op), .target(target), .cond(cond),
        .psr_in(psr_in), .irq(irq), .irq_mask(irq_mask), .pc(pc), .psr_out(psr_out),
        .psr_restore(psr_restore), .irq_ack(irq_ack), .in_isr(in_isr), .depth(depth),
        .stack_ovf(stack_ovf), .stack_unf(stack_unf)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_pc;
    logic [15:0] m_stk[$];
    bit          m_isr, m_ovf, m_unf, m_restore;
    logic [4:0]  m_saved, m_psr_out;
    logic [3:0]  m_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("pc", 32'(pc), 32'(m_pc));
        check("depth", 32'(depth), 32'(m_stk.size()));
        check("in_isr", 32'(in_isr), 32'(m_isr));
        check("ovf", 32'(stack_ovf), 32'(m_ovf));
        check("unf", 32'(stack_unf), 32'(m_unf));
        check("irq_ack", 32'(irq_ack), 32'(m_ack));
        check("psr_restore", 32'(psr_restore), 32'(m_restore));
        if (m_restore) check("psr_out", 32'(psr_out), 32'(m_psr_out));
    endtask

    task automatic model_step(input logic [2:0] o, input logic [15:0] t, input logic c,
                              input logic [4:0] p, input logic [3:0] i, input logic [3:0] m);
        int ob, idx;
        logic [15:0] npc;
        logic [3:0] pend;
        ob = (o == 3'd7) ? 0 : int'(o);
        pend = i & m;
        m_ack = '0;
        m_restore = 0;
        idx = 0;
        while (idx < 3 && !pend[idx]) idx++;
        case (ob)
            1: npc = t;
            2: npc = c ? m_pc + t : m_pc + 16'd1;
            6: npc = m_pc;
            default: npc = m_pc + 16'd1;
        endcase
        if (pend != 0 && !m_isr && ob inside {0, 1, 2, 6} && m_stk.size() < 8) begin
            m_stk.push_back(npc);
            m_pc = 16'h0010 + 16'(idx * 4);
            m_isr = 1;
            m_saved = p;
            m_ack = 4'(1 << idx);
        end else if (ob == 3) begin
            if (m_stk.size() == 8) m_ovf = 1;
            else m_stk.push_back(m_pc + 16'd1);
            m_pc = t;
        end else if (ob == 4 || ob == 5) begin
            if (m_stk.size() == 0) begin
                m_unf = 1;
                m_pc = m_pc + 16'd1;
            end else begin
                m_pc = m_stk.pop_back();
                if (ob == 5 && m_isr) begin
                    m_isr = 0;
                    m_restore = 1;
                    m_psr_out = m_saved;
                end
            end
        end else m_pc = npc;
    endtask

    task automatic do_step(input logic [2:0] o, input logic [15:0] t, input logic c,
                           input logic [4:0] p, input logic [3:0] i, input logic [3:0] m);
        step = 1; op = o; target = t; cond = c; psr_in = p; irq = i; irq_mask = m;
        @(posedge clock);
        #1;
        step = 0;
        model_step(o, t, c, p, i, m);
        check_all();
    endtask

    task automatic do_idle();
        step = 0;
        op = 3'($urandom); irq = 4'($urandom); irq_mask = 4'hF;
        @(posedge clock);
        #1;
        m_ack = '0;
        m_restore = 0;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1; step = 1; op = 3'b011; target = 16'h1234; irq = 4'hF; irq_mask = 4'hF;
        @(posedge clock);
        #1;
        reset = 0; step = 0; irq = '0;
        m_pc = '0; m_stk.delete(); m_isr = 0; m_ovf = 0; m_unf = 0;
        m_ack = '0; m_restore = 0; m_saved = '0; m_psr_out = '0;
        check_all();
        check("rst_psr_out", 32'(psr_out), 32'h0);
    endtask

    initial begin
        do_reset();
        repeat (3) do_step(3'b000, '0, 0, '0, '0, '0);
        check("inc3_pc", 32'(pc), 32'h3);
        do_step(3'b001, 16'hFFFF, 0, '0, '0, '0);
        do_step(3'b000, '0, 0, '0, '0, '0);
        check("wrap_pc", 32'(pc), 32'h0);
        do_step(3'b001, 16'h0020, 0, '0, '0, '0);
        do_step(3'b010, 16'hFFFC, 1, '0, '0, '0);
        check("br_taken", 32'(pc), 32'h001C);
        do_step(3'b001, 16'h0020, 0, '0, '0, '0);
        do_step(3'b010, 16'hFFFC, 0, '0, '0, '0);
        check("br_not", 32'(pc), 32'h0021);
        do_step(3'b001, 16'h0005, 0, '0, '0, '0);
        do_step(3'b011, 16'h0100, 0, '0, '0, '0);
        check("call_pc", 32'(pc), 32'h0100);
        check("call_depth", 32'(depth), 32'h1);
        do_step(3'b100, '0, 0, '0, '0, '0);
        check("ret_pc", 32'(pc), 32'h6);
        do_step(3'b110, '0, 0, '0, '0, '0);
        do_idle();
        do_step(3'b111, '0, 0, '0, '0, '0);

        do_reset();
        for (int k = 0; k < 9; k++) do_step(3'b011, 16'(k * 16 + 3), 0, '0, '0, '0);
        check("ovf_flag", 32'(stack_ovf), 32'h1);
        check("ovf_depth", 32'(depth), 32'h8);
        do_step(3'b000, '0, 0, '0, 4'hF, 4'hF);
        for (int k = 0; k < 8; k++) do_step(3'b100, '0, 0, '0, '0, '0);
        do_step(3'b100, '0, 0, '0, '0, '0);
        check("unf_flag", 32'(stack_unf), 32'h1);

        do_reset();
        do_step(3'b001, 16'h0007, 0, '0, '0, '0);
        do_step(3'b000, '0, 0, 5'b10001, 4'b0110, 4'b1111);
        check("isr_pc", 32'(pc), 32'h0014);
        check("isr_ack", 32'(irq_ack), 32'h2);
        do_idle();
        do_step(3'b101, '0, 0, 5'b00000, 4'b0000, 4'b1111);
        check("reti_pc", 32'(pc), 32'h8);
        check("reti_psr", 32'(psr_out), 32'h11);
        check("reti_pulse", 32'(psr_restore), 32'h1);

        do_reset();
        do_step(3'b011, 16'h0040, 0, '0, 4'b0001, 4'b1111);
        check("call_no_irq", 32'(in_isr), 32'h0);
        do_step(3'b000, '0, 0, 5'b00101, 4'b0001, 4'b1111);
        check("irq_after_call", 32'(pc), 32'h0010);
        do_step(3'b011, 16'h0200, 0, '0, 4'b1000, 4'b1111);
        do_step(3'b100, '0, 0, '0, 4'b1000, 4'b1111);
        do_reset();
        check("rst_isr", 32'(in_isr), 32'h0);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            else if ($urandom_range(0, 7) == 0) do_idle();
            else do_step(3'($urandom), 16'($urandom), 1'($urandom),
                         5'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, meaning program counter and target width.
REQ-002 SHALL provide parameter STACK_DEPTH, default 8, meaning number of hardware return-stack entries (at least 2).
REQ-003 SHALL provide parameter IRQ_N, default 4, meaning number of interrupt request lines.
REQ-004 SHALL provide parameter RESET_ADDR, default 0, meaning the PC value after reset.
REQ-005 SHALL provide parameter VEC_BASE, default 16'h0010, meaning the first interrupt vector address.
REQ-006 SHALL provide parameter VEC_STRIDE, default 4, meaning the address spacing between consecutive interrupt vectors.
REQ-007 SHALL provide port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL provide port step, input, 1 bit: instruction-boundary strobe from the control FSM; state changes only when step=1.
REQ-010 SHALL provide port op, input, 3 bits: 000 INC, 001 JUMP, 010 BRANCH, 011 CALL, 100 RET, 101 RETI, 110 HOLD, 111 treated as INC.
REQ-011 SHALL provide port target, input, ADDR_W bits: absolute address (JUMP, CALL) or two's-complement offset (BRANCH).
REQ-012 SHALL provide port cond, input, 1 bit: branch-taken qualifier for BRANCH.
REQ-013 SHALL provide port psr_in, input, 5 bits: live {N,Z,O,L,C} flags to save on interrupt entry.
REQ-014 SHALL provide port irq, input, IRQ_N bits: level-sensitive interrupt requests.
REQ-015 SHALL provide port irq_mask, input, IRQ_N bits: 1 enables the corresponding line.
REQ-016 SHALL provide port pc, output, ADDR_W bits: current program counter.
REQ-017 SHALL provide port psr_out, output, 5 bits: saved flags, valid while psr_restore=1.
REQ-018 SHALL provide port psr_restore, output, 1 bit: one-cycle pulse on RETI from an ISR.
REQ-019 SHALL provide port irq_ack, output, IRQ_N bits: one-hot, one-cycle pulse identifying the interrupt taken.
REQ-020 SHALL provide port in_isr, output, 1 bit: set while an interrupt service routine is executing.
REQ-021 SHALL provide port depth, output, clog2(STACK_DEPTH+1) bits: current stack occupancy.
REQ-022 SHALL provide ports stack_ovf and stack_unf, output, 1 bit each: sticky error flags.

Function
REQ-023 SHALL compute the next PC (npc) on step as follows: INC gives pc+1; JUMP gives target; BRANCH gives pc+target when cond=1, else pc+1; HOLD gives pc.
REQ-024 SHALL, on CALL, push pc+1 and set npc=target.
REQ-025 SHALL, on RET and RETI, pop the top entry into npc.
REQ-026 SHALL perform all PC arithmetic modulo 2^ADDR_W, so that max+1 wraps to 0 and negative offsets wrap.
REQ-027 SHALL, on CALL with depth=STACK_DEPTH, set stack_ovf, discard the push and still jump to target.
REQ-028 SHALL, on RET or RETI with depth=0, set stack_unf and set npc=pc+1, with no psr_restore.
REQ-029 SHALL define an interrupt as pending when (irq & irq_mask)!=0 and in_isr=0; the lowest-index pending line has priority.
REQ-030 SHALL take a pending interrupt only on a step with op in {INC, JUMP, BRANCH, HOLD} and depth<STACK_DEPTH; otherwise it is deferred with no flag set.
REQ-031 SHALL, when taking an interrupt: push npc, save psr_in, set pc=VEC_BASE+idx*VEC_STRIDE, set in_isr=1, and pulse irq_ack[idx] in the cycle after step.
REQ-032 SHALL, on RETI with in_isr=1 and depth>0, pop to pc, clear in_isr, drive psr_out=saved PSR and pulse psr_restore for one cycle.
REQ-033 SHALL treat RETI with in_isr=0 as RET.
REQ-034 SHALL not nest interrupts, and SHALL allow CALL/RET inside an ISR using the same stack.
REQ-035 SHALL make pc and depth reflect the step's effect one cycle after step; with step=0 all state holds and all pulses are 0.

Reset
REQ-036 SHALL, on reset=1 at a clock edge, set pc=RESET_ADDR, depth=0, in_isr=0, stack_ovf=0, stack_unf=0, irq_ack=0, psr_restore=0 and psr_out=0.
REQ-037 SHALL give reset priority over step and irq in the same cycle, discarding any in-flight operation.

Verification
REQ-038 SHALL verify: reset, then 3 INC steps -> pc=3; pc=16'hFFFF, INC -> pc=0.
REQ-039 SHALL verify: pc=16'h0020, BRANCH target=16'hFFFC cond=1 -> pc=16'h001C; same with cond=0 -> pc=16'h0021.
REQ-040 SHALL verify: pc=5, CALL target=16'h0100 -> pc=16'h0100, depth=1; RET -> pc=6, depth=0.
REQ-041 SHALL verify: 9 nested CALLs with STACK_DEPTH=8 -> stack_ovf=1, depth=8; then RET at depth 0 -> stack_unf=1.
REQ-042 SHALL verify: irq=4'b0110, mask=4'b1111, pc=7, INC with psr_in=5'b10001 -> pc=16'h0014, irq_ack=4'b0010, in_isr=1; RETI -> pc=8, psr_out=5'b10001, psr_restore pulse, in_isr=0.
REQ-043 SHALL verify: irq asserted on a CALL step -> not taken; taken on the following INC step; reset asserted mid-ISR -> pc=RESET_ADDR, in_isr=0.
